// File: rtl/regfile_wb_sched_pkg.sv
// ============================================================================
// regfile_wb_sched_pkg : shared widths and grant-source encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package regfile_wb_sched_pkg;

  localparam int REG_W    = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  // Enum value doubles as the req/gnt bit index inside the arbiter.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_sched_if.sv
// ============================================================================
// regfile_wb_sched_if : issue, writeback, write-port and hazard bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface regfile_wb_sched_if;

  logic                                      issue_valid;
  logic [regfile_wb_sched_pkg::ADDR_W-1:0]   issue_add;
  logic                                      issue_ready;

  logic                                      alu_valid;
  logic [regfile_wb_sched_pkg::ADDR_W-1:0]   alu_add;
  logic [regfile_wb_sched_pkg::REG_W-1:0]    alu_data;
  logic                                      alu_ready;

  logic                                      mem_valid;
  logic [regfile_wb_sched_pkg::ADDR_W-1:0]   mem_add;
  logic [regfile_wb_sched_pkg::REG_W-1:0]    mem_data;
  logic                                      mem_ready;

  logic [regfile_wb_sched_pkg::REG_W-1:0]    writeData;
  logic [regfile_wb_sched_pkg::ADDR_W-1:0]   writeAdd;
  logic                                      writeEn;

  logic [regfile_wb_sched_pkg::ADDR_W-1:0]   read1Add;
  logic [regfile_wb_sched_pkg::ADDR_W-1:0]   read2Add;
  logic                                      hazard1;
  logic                                      hazard2;

  logic [regfile_wb_sched_pkg::NUM_REGS-1:0] busy;

  modport master (
    output issue_valid, issue_add, input issue_ready,
    output alu_valid, alu_add, alu_data, input alu_ready,
    output mem_valid, mem_add, mem_data, input mem_ready,
    input  writeData, writeAdd, writeEn,
    output read1Add, read2Add, input hazard1, hazard2,
    input  busy
  );

  modport slave (
    input  issue_valid, issue_add, output issue_ready,
    input  alu_valid, alu_add, alu_data, output alu_ready,
    input  mem_valid, mem_add, mem_data, output mem_ready,
    output writeData, writeAdd, writeEn,
    input  read1Add, read2Add, output hazard1, hazard2,
    output busy
  );

endinterface

`default_nettype wire

// File: rtl/regfile_wb_sched_rr_arb2.sv
// ============================================================================
// rr_arb2 : two-way round-robin arbiter, bit 0 = ALU, bit 1 = MEM
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb2
  import regfile_wb_sched_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [1:0] req_i,
  output logic      [1:0] gnt_o
);

  src_e last_q;
  src_e last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    // On contention the source that did not win last time takes the slot.
    if (req_i[0] && (!req_i[1] || (last_q == SRC_MEM))) begin
      gnt_o[0] = 1'b1;
      last_d   = SRC_ALU;
    end else if (req_i[1]) begin
      gnt_o[1] = 1'b1;
      last_d   = SRC_MEM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= SRC_MEM;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_sched.sv
// ============================================================================
// regfile_wb_sched : destination scoreboard plus arbitrated single write port
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst,
  regfile_wb_sched_if.slave  bus
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                writeEn_q;
  logic                writeEn_d;
  logic [ADDR_W-1:0]   writeAdd_q;
  logic [ADDR_W-1:0]   writeAdd_d;
  logic [REG_W-1:0]    writeData_q;
  logic [REG_W-1:0]    writeData_d;

  logic [1:0]          w_req;
  logic [1:0]          w_gnt;
  logic                w_issue_ready;
  logic [ADDR_W-1:0]   w_win_add;
  logic [REG_W-1:0]    w_win_data;

  assign w_req = {bus.mem_valid, bus.alu_valid};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (w_req),
    .gnt_o (w_gnt)
  );

  assign w_issue_ready = !busy_q[bus.issue_add];
  assign w_win_add     = w_gnt[1] ? bus.mem_add  : bus.alu_add;
  assign w_win_data    = w_gnt[1] ? bus.mem_data : bus.alu_data;

  always_comb begin
    busy_d      = busy_q;
    writeEn_d   = 1'b0;
    writeAdd_d  = writeAdd_q;
    writeData_d = writeData_q;
    if (bus.issue_valid && w_issue_ready) begin
      busy_d[bus.issue_add] = 1'b1;
    end
    // Clear after set so a writeback always wins on the same register.
    if (|w_gnt) begin
      busy_d[w_win_add] = 1'b0;
      writeEn_d         = 1'b1;
      writeAdd_d        = w_win_add;
      writeData_d       = w_win_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      writeEn_q   <= 1'b0;
      writeAdd_q  <= '0;
      writeData_q <= '0;
    end else begin
      busy_q      <= busy_d;
      writeEn_q   <= writeEn_d;
      writeAdd_q  <= writeAdd_d;
      writeData_q <= writeData_d;
    end
  end

  assign bus.issue_ready = w_issue_ready;
  assign bus.alu_ready   = w_gnt[0];
  assign bus.mem_ready   = w_gnt[1];
  assign bus.writeEn     = writeEn_q;
  assign bus.writeAdd    = writeAdd_q;
  assign bus.writeData   = writeData_q;
  assign bus.busy        = busy_q;
  assign bus.hazard1     = busy_q[bus.read1Add] | (writeEn_q && (writeAdd_q == bus.read1Add));
  assign bus.hazard2     = busy_q[bus.read2Add] | (writeEn_q && (writeAdd_q == bus.read2Add));

endmodule

`default_nettype wire

// File: doc/regfile_wb_sched.md
REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 issue_valid  input  1  issuing instruction requests reservation of a destination register.
REQ-004 issue_add  input  5  destination register to reserve.
REQ-005 issue_ready  output  1  reservation accepted this cycle; combinational.
REQ-006 alu_valid / alu_add / alu_data  input  1/5/32  ALU writeback request.
REQ-007 alu_ready  output  1  ALU request granted this cycle; combinational.
REQ-008 mem_valid / mem_add / mem_data  input  1/5/32  load-unit writeback request.
REQ-009 mem_ready  output  1  load request granted this cycle; combinational.
REQ-010 writeData / writeAdd / writeEn  output  32/5/1  registered drive of the register-file write port.
REQ-011 read1Add / read2Add  input  5  register-file read addresses to hazard-check.
REQ-012 hazard1 / hazard2  output  1  read of that address returns stale data; combinational.
REQ-013 busy  output  32  scoreboard bitmap, bit n = register n has a pending write.

Function
REQ-014 Scoreboard SHALL set busy[issue_add] on an edge where issue_valid && issue_ready.
REQ-015 issue_ready SHALL equal !busy[issue_add], which stalls WAW issue.
REQ-016 Arbiter SHALL grant at most one source per cycle: alu_ready / mem_ready high only if the matching valid is high and that source wins.
REQ-017 Single valid source SHALL always win; if both are valid, the source not granted most recently SHALL win (round-robin); after reset ALU has priority.
REQ-018 The last-grant pointer SHALL update only on a granted cycle.
REQ-019 On a granted edge the scheduler SHALL register the winner's add/data into writeAdd/writeData, set writeEn=1, and clear busy[winner add].
REQ-020 writeEn SHALL be 1 for exactly one cycle per grant (latency 1 from handshake), else 0; writeData/writeAdd hold their last value when writeEn=0.
REQ-021 Back-to-back grants SHALL produce writeEn high on consecutive cycles with no bubble.
REQ-022 Writeback to a register whose busy bit is clear SHALL still be forwarded; busy stays 0.
REQ-023 Issue and writeback on the same edge to different registers SHALL both take effect.
REQ-024 Issue and writeback on the same edge to the same register cannot both succeed: issue_ready is 0 because busy=1, and the writeback wins.
REQ-025 hazardN SHALL equal busy[readNAdd] | (writeEn && writeAdd==readNAdd).
REQ-026 All 32 registers SHALL be treated identically; there is no hardwired zero.

Reset
REQ-027 While rst=1: busy=0, writeEn=0, writeData=0, writeAdd=0, last-grant pointer = MEM (so ALU wins first).
REQ-028 Reset mid-operation SHALL discard all pending reservations and any in-flight write; no writeEn after reset deasserts until a new grant.
REQ-029 Combinational outputs SHALL follow reset state (issue_ready=1 when issue_valid, hazards=0 unless inputs dictate).

Structure
REQ-030 Shared package SHALL hold REG_W=32, ADDR_W=5, NUM_REGS=32, and the grant-source enum {SRC_ALU, SRC_MEM}.
REQ-031 The two-way round-robin arbiter SHALL be one sub-module, rr_arb2 (req[1:0] in, gnt[1:0] out, pointer state inside).
REQ-032 Scoreboard and write-port register SHALL reside in regfile_wb_sched.

Verification
REQ-033 Issue r5, then alu writeback r5=0xDEADBEEF -> busy[5] 1 then 0; next cycle writeEn=1, writeAdd=5, writeData=0xDEADBEEF.
REQ-034 alu and mem both valid for 4 cycles, r1/r2 -> grants ALU, MEM, ALU, MEM; writeEn high 4 consecutive cycles.
REQ-035 busy[7]=1, issue_valid with issue_add=7 -> issue_ready=0 until the r7 writeback edge, then 1.
REQ-036 read1Add=9 with busy[9]=1 -> hazard1=1; cycle after grant (writeEn, writeAdd=9) -> hazard1=1; following cycle -> hazard1=0.
REQ-037 Issue r3 and mem writeback r4 on same edge -> busy[3]=1, busy[4]=0, writeAdd=4.
REQ-038 rst pulse while busy=0x0000_00F0 and a grant in flight -> busy=0, writeEn=0 immediately; first grant after reset goes to ALU.
